// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states
// and small op-classification helpers.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } mdu_state_e;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Sequencer for the shared multi-cycle multiply/divide datapath: arbitrates the
// two E-stage issue slots, starts the unit, stalls the pipe and writes HI/LO.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  E_master_mdu_op,
  input  logic [2:0]  E_slave_mdu_op,
  input  logic        E_master_rt_zero,
  input  logic        E_slave_rt_zero,
  input  logic        E_flush,
  output logic        mdu_sel_slave,
  output logic        mul_start,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_abort,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        mdu_stall,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata
);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        served_q, served_d;
  logic        slot_q, slot_d;
  logic [2:0]  op_q, op_d;
  logic        nowr_q, nowr_d;
  logic [63:0] result_q, result_d;

  logic        req_m, req_s, pick_slave, pick_zero;
  logic [2:0]  pick_op;

  // Master wins unless it was already served while the slave waits behind it.
  assign req_m      = (E_master_mdu_op != MDU_NONE) && !served_q;
  assign req_s      = (E_slave_mdu_op != MDU_NONE);
  assign pick_slave = !req_m && req_s;
  assign pick_op    = pick_slave ? E_slave_mdu_op : E_master_mdu_op;
  assign pick_zero  = pick_slave ? E_slave_rt_zero : E_master_rt_zero;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    served_d   = served_q;
    slot_d     = slot_q;
    op_d       = op_q;
    nowr_d     = nowr_q;
    result_d   = result_q;
    mdu_sel_slave = 1'b0;
    mul_start  = 1'b0;
    mul_signed = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_abort  = 1'b0;
    mdu_stall  = 1'b0;
    hilo_we    = 1'b0;
    hilo_wdata = '0;

    unique case (state_q)
      ST_IDLE: begin
        mdu_sel_slave = pick_slave;
        if (req_m || req_s) begin
          mdu_stall = 1'b1;
          slot_d    = pick_slave;
          op_d      = pick_op;
          nowr_d    = 1'b0;
          if (is_mul(pick_op)) begin
            mul_start  = 1'b1;
            mul_signed = is_signed_op(pick_op);
            cnt_d      = 4'(MUL_LAT - 1);
            if (MUL_LAT == 1) begin
              result_d = mul_result;
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_MUL_WAIT;
            end
          end else begin
            div_signed = is_signed_op(pick_op);
            if (pick_zero) begin
              // Divide by zero leaves HI/LO untouched and never starts the divider.
              nowr_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              div_start = 1'b1;
              state_d   = ST_DIV_WAIT;
            end
          end
        end else begin
          served_d = 1'b0;
        end
      end

      ST_MUL_WAIT: begin
        mdu_sel_slave = slot_q;
        mul_signed    = is_signed_op(op_q);
        mdu_stall     = 1'b1;
        cnt_d         = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          result_d = mul_result;
          state_d  = ST_DONE;
        end
      end

      ST_DIV_WAIT: begin
        mdu_sel_slave = slot_q;
        div_signed    = is_signed_op(op_q);
        mdu_stall     = 1'b1;
        if (div_done) begin
          result_d = {div_r, div_q};
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        mdu_sel_slave = slot_q;
        mul_signed    = is_mul(op_q) && is_signed_op(op_q);
        div_signed    = !is_mul(op_q) && is_signed_op(op_q);
        hilo_we       = !nowr_q;
        hilo_wdata    = nowr_q ? 64'd0 : result_q;
        state_d       = ST_IDLE;
        // Keep the pipe frozen so the slave op is still in E for its turn.
        if (!slot_q && req_s) begin
          mdu_stall = 1'b1;
          served_d  = 1'b1;
        end else begin
          served_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (E_flush) begin
      state_d    = ST_IDLE;
      served_d   = 1'b0;
      mdu_stall  = 1'b0;
      hilo_we    = 1'b0;
      hilo_wdata = '0;
      mul_start  = 1'b0;
      div_start  = 1'b0;
      mul_signed = 1'b0;
      div_signed = 1'b0;
      div_abort  = (state_q == ST_DIV_WAIT);
    end

    if (rst) begin
      mdu_sel_slave = 1'b0;
      mul_start  = 1'b0;
      mul_signed = 1'b0;
      div_start  = 1'b0;
      div_signed = 1'b0;
      div_abort  = 1'b0;
      mdu_stall  = 1'b0;
      hilo_we    = 1'b0;
      hilo_wdata = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      served_q <= 1'b0;
      slot_q   <= 1'b0;
      op_q     <= '0;
      nowr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      served_q <= served_d;
      slot_q   <= slot_d;
      op_q     <= op_d;
      nowr_q   <= nowr_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, timeline-model
// random transactions and hand sequences for flush and reset corners.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  E_master_mdu_op, E_slave_mdu_op;
  logic        E_master_rt_zero, E_slave_rt_zero, E_flush;
  logic        mdu_sel_slave, mul_start, mul_signed;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_abort, div_done;
  logic [31:0] div_q, div_r;
  logic        mdu_stall, hilo_we;
  logic [63:0] hilo_wdata;

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .E_master_mdu_op(E_master_mdu_op), .E_slave_mdu_op(E_slave_mdu_op),
    .E_master_rt_zero(E_master_rt_zero), .E_slave_rt_zero(E_slave_rt_zero),
    .E_flush(E_flush), .mdu_sel_slave(mdu_sel_slave),
    .mul_start(mul_start), .mul_signed(mul_signed), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_abort(div_abort),
    .div_done(div_done), .div_q(div_q), .div_r(div_r),
    .mdu_stall(mdu_stall), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  mop, sop;
    logic        mz, sz;
    int          dlat_m, dlat_s;
    logic [63:0] mres_m, mres_s;
    logic [31:0] q_m, r_m, q_s, r_s;
    int          exp_writes, exp_end;
  } txn_t;

  function automatic logic op_is_mul(input logic [2:0] op);
    return op == 3'd1 || op == 3'd2;
  endfunction

  // Cycles from issue to the DONE cycle of one operation.
  function automatic int op_len(input logic [2:0] op, input logic z, input int dlat);
    if (op_is_mul(op)) return MUL_LAT;
    if (z) return 1;
    return dlat + 1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    E_master_mdu_op = 3'd0; E_slave_mdu_op = 3'd0;
    E_master_rt_zero = 1'b0; E_slave_rt_zero = 1'b0;
    E_flush = 1'b0; div_done = 1'b0;
    mul_result = 64'd0; div_q = 32'd0; div_r = 32'd0;
  endtask

  // Runs one E-stage instruction pair while it is held by the stall; the
  // expected cycle-by-cycle picture comes from op lengths laid end to end.
  task automatic run_txn(input txn_t t, input string tag,
                         output int writes, output int obs_end,
                         output int mdl_writes, output int mdl_end);
    bit has_m, has_s, act_s, is_m, z, exp_we;
    int m_len, s_start, len, rel, dlat;
    logic [2:0]  op;
    logic [63:0] mres, exp_data;
    logic [31:0] q, r;
    has_m = (t.mop != 3'd0);
    has_s = (t.sop != 3'd0);
    m_len = has_m ? op_len(t.mop, t.mz, t.dlat_m) : -1;
    s_start = m_len + 1;
    mdl_end = has_s ? s_start + op_len(t.sop, t.sz, t.dlat_s) : m_len;
    writes = 0; obs_end = -1; mdl_writes = 0;
    for (int c = 0; c <= mdl_end; c++) begin
      act_s = !(has_m && c <= m_len);
      op   = act_s ? t.sop : t.mop;
      z    = act_s ? t.sz : t.mz;
      dlat = act_s ? t.dlat_s : t.dlat_m;
      mres = act_s ? t.mres_s : t.mres_m;
      q    = act_s ? t.q_s : t.q_m;
      r    = act_s ? t.r_s : t.r_m;
      rel  = act_s ? c - s_start : c;
      len  = op_len(op, z, dlat);
      is_m = op_is_mul(op);
      E_master_mdu_op = t.mop; E_slave_mdu_op = t.sop;
      E_master_rt_zero = t.mz; E_slave_rt_zero = t.sz; E_flush = 1'b0;
      mul_result = is_m ? mres : {$urandom, $urandom};
      div_done = !is_m && !z && rel == dlat;
      div_q = div_done ? q : $urandom;
      div_r = div_done ? r : $urandom;
      exp_we = (rel == len) && (is_m || !z);
      exp_data = is_m ? mres : {r, q};
      @(negedge clk);
      check($sformatf("%s c%0d stall", tag, c), 64'(mdu_stall), 64'(c < mdl_end));
      check($sformatf("%s c%0d mul_start", tag, c), 64'(mul_start), 64'(is_m && rel == 0));
      check($sformatf("%s c%0d div_start", tag, c), 64'(div_start), 64'(!is_m && !z && rel == 0));
      check($sformatf("%s c%0d hilo_we", tag, c), 64'(hilo_we), 64'(exp_we));
      check($sformatf("%s c%0d sel", tag, c), 64'(mdu_sel_slave), 64'(act_s));
      check($sformatf("%s c%0d mul_signed", tag, c), 64'(mul_signed), 64'(op == 3'd1));
      check($sformatf("%s c%0d div_signed", tag, c), 64'(div_signed), 64'(op == 3'd3));
      check($sformatf("%s c%0d div_abort", tag, c), 64'(div_abort), 64'd0);
      if (exp_we) check($sformatf("%s c%0d wdata", tag, c), hilo_wdata, exp_data);
      if (hilo_we === 1'b1) writes++;
      if (mdu_stall === 1'b0 && obs_end < 0) obs_end = c;
      if (exp_we) mdl_writes++;
      cyc();
    end
    drive_idle();
    @(negedge clk);
    check({tag, " idle stall"}, 64'(mdu_stall), 64'd0);
    check({tag, " idle hilo_we"}, 64'(hilo_we), 64'd0);
    cyc();
  endtask

  txn_t vec[7];
  txn_t tr;
  int   w, oe, mw, me;

  initial begin
    vec[0] = '{3'd1, 3'd0, 1'b0, 1'b0, 0, 0, 64'h1_0000_0002, 64'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 3};
    vec[1] = '{3'd4, 3'd0, 1'b0, 1'b0, 33, 0, 64'd0, 64'd0, 32'd7, 32'd3, 32'd0, 32'd0, 1, 34};
    vec[2] = '{3'd1, 3'd3, 1'b0, 1'b0, 0, 5, 64'hDEAD_BEEF_0123_4567, 64'd0, 32'd0, 32'd0, 32'hFFFF_FFF9, 32'd1, 2, 10};
    vec[3] = '{3'd3, 3'd0, 1'b1, 1'b0, 4, 0, 64'd0, 64'd0, 32'd5, 32'd5, 32'd0, 32'd0, 0, 1};
    vec[4] = '{3'd0, 3'd2, 1'b0, 1'b0, 0, 0, 64'd0, 64'hFFFF_0000_FFFF_0000, 32'd0, 32'd0, 32'd0, 32'd0, 1, 3};
    vec[5] = '{3'd4, 3'd1, 1'b1, 1'b0, 2, 0, 64'd0, 64'h8000_0000_0000_0001, 32'd9, 32'd9, 32'd0, 32'd0, 1, 5};
    vec[6] = '{3'd2, 3'd1, 1'b0, 1'b0, 0, 0, 64'h0000_0001_2345_6789, 64'hFEDC_BA98_7654_3210, 32'd0, 32'd0, 32'd0, 32'd0, 2, 7};

    drive_idle();
    rst = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    check("reset stall", 64'(mdu_stall), 64'd0);
    check("reset hilo_we", 64'(hilo_we), 64'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("post-reset stall", 64'(mdu_stall), 64'd0);
    check("post-reset sel", 64'(mdu_sel_slave), 64'd0);
    cyc();

    for (int i = 0; i < 7; i++) begin
      run_txn(vec[i], $sformatf("vec%0d", i), w, oe, mw, me);
      check($sformatf("vec%0d writes", i), 64'(w), 64'(vec[i].exp_writes));
      check($sformatf("vec%0d end", i), 64'(oe), 64'(vec[i].exp_end));
    end

    for (int i = 0; i < 40; i++) begin
      tr.mop = 3'($urandom_range(0, 4));
      tr.sop = 3'($urandom_range(0, 4));
      if (tr.mop == 3'd0 && tr.sop == 3'd0) tr.sop = 3'd3;
      tr.mz = ($urandom_range(0, 3) == 0);
      tr.sz = ($urandom_range(0, 3) == 0);
      tr.dlat_m = $urandom_range(1, 12);
      tr.dlat_s = $urandom_range(1, 12);
      tr.mres_m = {$urandom, $urandom};
      tr.mres_s = {$urandom, $urandom};
      tr.q_m = $urandom; tr.r_m = $urandom; tr.q_s = $urandom; tr.r_s = $urandom;
      tr.exp_writes = 0; tr.exp_end = 0;
      run_txn(tr, $sformatf("rnd%0d", i), w, oe, mw, me);
      check($sformatf("rnd%0d writes", i), 64'(w), 64'(mw));
      check($sformatf("rnd%0d end", i), 64'(oe), 64'(me));
    end

    // Flush while the divider runs: abort pulse, no write, late div_done ignored.
    E_master_mdu_op = 3'd4;
    @(negedge clk);
    check("flush div_start", 64'(div_start), 64'd1);
    cyc();
    for (int c = 1; c < 10; c++) cyc();
    E_flush = 1'b1;
    @(negedge clk);
    check("flush div_abort", 64'(div_abort), 64'd1);
    check("flush stall", 64'(mdu_stall), 64'd0);
    check("flush hilo_we", 64'(hilo_we), 64'd0);
    cyc();
    drive_idle();
    @(negedge clk);
    check("flush after abort", 64'(div_abort), 64'd0);
    check("flush after stall", 64'(mdu_stall), 64'd0);
    cyc();
    div_done = 1'b1; div_q = 32'h1234_5678; div_r = 32'h9;
    @(negedge clk);
    check("stray div_done hilo_we", 64'(hilo_we), 64'd0);
    cyc();
    div_done = 1'b0;
    @(negedge clk);
    check("stray div_done late hilo_we", 64'(hilo_we), 64'd0);
    check("stray div_done stall", 64'(mdu_stall), 64'd0);
    cyc();

    // Flush landing on DONE suppresses the write.
    E_master_mdu_op = 3'd1; mul_result = 64'h55;
    cyc(); cyc(); cyc();
    E_flush = 1'b1;
    @(negedge clk);
    check("flush-done hilo_we", 64'(hilo_we), 64'd0);
    check("flush-done stall", 64'(mdu_stall), 64'd0);
    cyc();
    drive_idle();
    @(negedge clk);
    check("flush-done after hilo_we", 64'(hilo_we), 64'd0);
    cyc();

    // Flush in the issue cycle: nothing starts.
    E_master_mdu_op = 3'd1; E_flush = 1'b1;
    @(negedge clk);
    check("flush-issue mul_start", 64'(mul_start), 64'd0);
    check("flush-issue stall", 64'(mdu_stall), 64'd0);
    cyc();
    drive_idle();
    @(negedge clk);
    check("flush-issue after stall", 64'(mdu_stall), 64'd0);
    cyc();

    // Reset in MUL_WAIT returns to the reset picture; the next MULT is normal.
    E_master_mdu_op = 3'd1; mul_result = 64'h77;
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("rst-mul stall during rst", 64'(mdu_stall), 64'd0);
    cyc();
    rst = 1'b0;
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst-mul c%0d stall", c), 64'(mdu_stall), 64'd0);
      check($sformatf("rst-mul c%0d hilo_we", c), 64'(hilo_we), 64'd0);
      check($sformatf("rst-mul c%0d mul_start", c), 64'(mul_start), 64'd0);
      cyc();
    end
    run_txn(vec[0], "rst-mul rerun", w, oe, mw, me);
    check("rst-mul rerun writes", 64'(w), 64'd1);
    check("rst-mul rerun end", 64'(oe), 64'(MUL_LAT));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Sequences the shared multi-cycle multiply/divide datapath for the dual-issue pipeline.
- Arbitrates between the master and slave issue slots in E.
- Starts the multiplier or divider and counts or awaits completion.
- Raises a stall request that the hazard unit ORs into its F/D/E enables.
- Delivers one 64-bit HI/LO write per completed operation.
- Sits between the E stage, the MDU datapath and the hazard unit.

Parameters:
- MUL_LAT, 3, multiplier latency in cycles from mul_start to a valid mul_result (1..15).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- E_master_mdu_op, in, 3, master slot op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU.
- E_slave_mdu_op, in, 3, slave slot op, same encoding.
- E_master_rt_zero, in, 1, master divisor is zero.
- E_slave_rt_zero, in, 1, slave divisor is zero.
- E_flush, in, 1, E-stage flush from the hazard unit (branch taken).
- mdu_sel_slave, out, 1, operand mux select: 0 master, 1 slave.
- mul_start, out, 1, one-cycle multiplier start.
- mul_signed, out, 1, signed multiply.
- mul_result, in, 64, product, valid MUL_LAT cycles after mul_start.
- div_start, out, 1, one-cycle divider start.
- div_signed, out, 1, signed divide.
- div_abort, out, 1, one-cycle divider abort.
- div_done, in, 1, divider completion pulse.
- div_q, in, 32, quotient, valid with div_done.
- div_r, in, 32, remainder, valid with div_done.
- mdu_stall, out, 1, stall request to the hazard unit.
- hilo_we, out, 1, HI/LO write enable.
- hilo_wdata, out, 64, {HI,LO} write data.

Behaviour:
- Reset: state IDLE, lat counter 0, served_master 0. All outputs 0.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- Requests: req_m = (master op != NONE) & ~served_master. req_s = (slave op != NONE).
- IDLE arbitration: master has priority. If req_m, latch slot=master and the op. Else if req_s, latch slot=slave.
- IDLE with a request and no E_flush:
  - Assert mdu_stall combinationally in that same cycle.
  - MULT/MULTU: pulse mul_start, load counter with MUL_LAT-1, go to MUL_WAIT.
  - DIV/DIVU with a nonzero divisor: pulse div_start, go to DIV_WAIT.
  - DIV/DIVU with a zero divisor: no start, go to DONE with a "no write" flag.
- mul_signed / div_signed: 1 for MULT/DIV. Held from start until DONE.
- mdu_sel_slave: reflects the latched slot. In IDLE it reflects the current arbitration choice.
- MUL_WAIT: decrement the counter. At 0, capture mul_result into a 64-bit result register and go to DONE.
- DIV_WAIT: on div_done, capture {div_r,div_q} (HI=remainder, LO=quotient) and go to DONE.
- mdu_stall is 1 in IDLE (when a request is taken), MUL_WAIT and DIV_WAIT.
- DONE lasts one cycle:
  - hilo_we=1 (0 for the divide-by-zero case), hilo_wdata = result register.
  - If slot=master and req_s: keep mdu_stall=1, set served_master=1, return to IDLE. The slave is then served next.
  - Otherwise mdu_stall=0, clear served_master, return to IDLE.
- Latency for a single MULT: issue at cycle 0; hilo_we at cycle MUL_LAT; mdu_stall high for cycles 0..MUL_LAT-1.
- E_flush in any state:
  - Next state IDLE, served_master cleared, no hilo_we in that cycle.
  - Combinational mdu_stall=0.
  - div_abort pulses if the state is DIV_WAIT.
  - E_flush has priority over DONE.
- div_done arriving outside DIV_WAIT is ignored.
- Reset mid-operation: identical to the reset state. No hilo_we, no abort pulse.
- hilo_we never asserts twice for one latched operation.

Decomposition:
- Shared defines header: op codes (MDU_NONE..MDU_DIVU) and state encodings.
- The hazard unit consumes mdu_stall. It gains one input and ORs it into its F/D/E enable logic.
- The latency counter and arbitration stay inline in the FSM. The datapath (multiplier, divider) is external; no sub-module inside this block.

Test Plan:
- Master MULT, MUL_LAT=3, mul_result=64'h1_0000_0002 -> mul_start at cycle 0; mdu_stall high cycles 0-2; hilo_we=1 at cycle 3 with that data.
- Master DIVU, div_done after 33 cycles, q=7, r=3 -> div_start once; stall high until done+1; hilo_wdata=64'h3_00000007.
- Master MULT + slave DIV in the same cycle -> master served first. Stall stays high through the master DONE. Slave div_start in the following cycle; two hilo_we pulses, master data first.
- DIV in progress, E_flush at cycle 10 -> div_abort pulse at cycle 10, state IDLE, mdu_stall 0, no hilo_we; a later div_done is ignored.
- DIV with E_master_rt_zero=1 -> no div_start; DONE next cycle with hilo_we=0; stall drops.
- rst asserted during MUL_WAIT -> all outputs 0 next cycle; a following MULT runs normally.
